// File: rtl/lights_pkg.sv
// Shared light encodings, controller state type and field sanity helper
// for the multi-channel traffic light controllers.
package lights_pkg;

  localparam logic [2:0] ST_STOP = 3'b001;
  localparam logic [2:0] ST_GO   = 3'b010;
  localparam logic [2:0] ST_SLOW = 3'b100;

  typedef enum logic [1:0] {IDLE, GO, SLOW, CLEAR} ctrl_state_t;

  function automatic logic onehot3_ok(input logic [2:0] f);
    return (f == ST_STOP) || (f == ST_GO) || (f == ST_SLOW);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin arbiter: picks the first requester strictly
// after `last`, wrapping, so `last` itself has the lowest priority.
module rr_pick #(
  parameter int unsigned NUM_CH = 4
) (
  input  logic [NUM_CH-1:0]         req,
  input  logic [$clog2(NUM_CH)-1:0] last,
  output logic                      valid,
  output logic [$clog2(NUM_CH)-1:0] idx
);

  localparam int unsigned IDX_W = $clog2(NUM_CH);

  always_comb begin
    int unsigned cand;
    valid = 1'b0;
    idx   = last;
    cand  = 0;
    for (int unsigned off = 1; off <= NUM_CH; off++) begin
      cand = (32'(last) + off) % NUM_CH;
      if (!valid && req[cand]) begin
        valid = 1'b1;
        idx   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/lights_rr_ctrl.sv
// Round-robin multi-channel STOP/GO/SLOW light controller with min/max GO
// dwell, SLOW duration, all-stop clearance and a sticky sanity error flag.
module lights_rr_ctrl
  import lights_pkg::*;
#(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned MIN_GO    = 4,
  parameter int unsigned MAX_GO    = 16,
  parameter int unsigned SLOW_CYC  = 2,
  parameter int unsigned CLEAR_CYC = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_CH-1:0]         req,
  output logic [3*NUM_CH-1:0]       state,
  output logic [$clog2(NUM_CH)-1:0] active_ch,
  output logic                      busy,
  output logic                      error
);

  localparam int unsigned IDX_W = $clog2(NUM_CH);
  localparam logic [CNT_W-1:0] CNT_SAT = '1;
  localparam logic [CNT_W-1:0] MIN_C   = CNT_W'(MIN_GO);
  localparam logic [CNT_W-1:0] MAX_C   = CNT_W'(MAX_GO);
  localparam logic [CNT_W-1:0] SLOW_C  = CNT_W'(SLOW_CYC);
  localparam logic [CNT_W-1:0] CLEAR_C = CNT_W'(CLEAR_CYC);

  (* covered_fsm = "lights_ctrl", is = "ctrl_q", os = "ctrl_d" *)
  ctrl_state_t ctrl_q, ctrl_d;

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    act_d;
  logic [3*NUM_CH-1:0] state_d;
  logic                busy_d;
  logic                pick_valid;
  logic [IDX_W-1:0]    pick_idx;
  logic                own_req, other_req, bad;

  rr_pick #(.NUM_CH(NUM_CH)) u_pick (
    .req   (req),
    .last  (active_ch),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_comb begin
    own_req   = 1'b0;
    other_req = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (IDX_W'(i) == active_ch) own_req = req[i];
      else if (req[i])            other_req = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q <= IDLE;
      cnt_q  <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      cnt_q  <= cnt_d;
    end
  end

  // Arbitration happens on leaving IDLE or at the end of clearance (or SLOW
  // when clearance is disabled); the served channel ranks last via active_ch.
  always_comb begin
    ctrl_d = ctrl_q;
    cnt_d  = cnt_q;
    act_d  = active_ch;
    unique case (ctrl_q)
      IDLE: begin
        if (pick_valid) begin
          ctrl_d = GO;
          cnt_d  = CNT_W'(1);
          act_d  = pick_idx;
        end
      end
      GO: begin
        if (cnt_q >= MIN_C && (!own_req || (cnt_q >= MAX_C && other_req))) begin
          ctrl_d = SLOW;
          cnt_d  = CNT_W'(1);
        end else if (cnt_q != CNT_SAT) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SLOW, CLEAR: begin
        if (cnt_q < ((ctrl_q == SLOW) ? SLOW_C : CLEAR_C)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else if (ctrl_q == SLOW && CLEAR_CYC != 0) begin
          ctrl_d = CLEAR;
          cnt_d  = CNT_W'(1);
        end else if (pick_valid) begin
          ctrl_d = GO;
          cnt_d  = CNT_W'(1);
          act_d  = pick_idx;
        end else begin
          ctrl_d = IDLE;
          cnt_d  = '0;
        end
      end
      default: begin
        ctrl_d = IDLE;
        cnt_d  = '0;
      end
    endcase
  end

  always_comb begin
    state_d = {NUM_CH{ST_STOP}};
    busy_d  = (ctrl_d == GO) || (ctrl_d == SLOW);
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (IDX_W'(i) == act_d) begin
        if (ctrl_d == GO)   state_d[3*i +: 3] = ST_GO;
        if (ctrl_d == SLOW) state_d[3*i +: 3] = ST_SLOW;
      end
    end
  end

  always_comb begin
    int unsigned n_live;
    n_live = 0;
    bad    = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (!onehot3_ok(state[3*i +: 3])) bad = 1'b1;
      if (state[3*i +: 3] != ST_STOP)   n_live++;
    end
    if (n_live > 1) bad = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= {NUM_CH{ST_STOP}};
      active_ch <= IDX_W'(NUM_CH - 1);
      busy      <= 1'b0;
      error     <= 1'b0;
    end else begin
      state     <= state_d;
      active_ch <= act_d;
      busy      <= busy_d;
      error     <= error | bad;
    end
  end

endmodule

// File: doc/lights_rr_ctrl.md
Name: lights_rr_ctrl

Overview:
- Parametrised successor to the single-channel one-hot STOP/GO/SLOW light FSM.
- Controls NUM_CH light channels, for example the approaches of an intersection.
- At most one channel is non-STOP at any time.
- Grants go round-robin among requesting channels, with programmable minimum and maximum GO dwell, SLOW duration and an all-stop clearance interval.
- Sits between request sensors and per-channel light drivers; exposes a one-hot sanity error flag for coverage and assertion checking.

Parameters:
- NUM_CH, 4, number of light channels (2..16).
- CNT_W, 8, dwell counter width in bits.
- MIN_GO, 4, minimum cycles a granted channel stays GO (1..2^CNT_W-1).
- MAX_GO, 16, maximum GO cycles while another channel is requesting (MIN_GO..2^CNT_W-1).
- SLOW_CYC, 2, cycles spent in SLOW (1..2^CNT_W-1).
- CLEAR_CYC, 1, all-STOP cycles between grants (0..2^CNT_W-1; 0 means no clearance).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NUM_CH  per-channel request, level-sensitive, sampled every clk.
- state  out  3*NUM_CH  per-channel one-hot light; channel i occupies bits [3i+2:3i]. STOP=3'b001, GO=3'b010, SLOW=3'b100.
- active_ch  out  $clog2(NUM_CH)  index of the channel currently GO or SLOW; holds the last served index when IDLE or CLEAR.
- busy  out  1  high when any channel is GO or SLOW.
- error  out  1  sticky; set when any channel field is not one-hot, or more than one channel is non-STOP.

Behaviour:
- Reset (rst_n low, asynchronous): every channel field is STOP, ctrl is IDLE, counter is 0, active_ch is NUM_CH-1 (so channel 0 wins first), busy is 0, error is 0. Reset mid-GO or mid-SLOW forces all channels to STOP immediately, with no SLOW phase.
- All outputs are registered. A state change becomes visible the cycle after the deciding edge.
- Controller states: IDLE, GO, SLOW, CLEAR.
- IDLE → GO when any req is high. The winner is the first requesting index after active_ch, modulo NUM_CH. Latency from req rising to the channel showing GO is 1 cycle. Counter loads 1.
- GO: counter increments each cycle and saturates at 2^CNT_W-1. Leave GO → SLOW when counter ≥ MIN_GO AND any of the following holds:
  - own req is low;
  - counter ≥ MAX_GO and another req is high.
- GO with own req high and no other req: stay GO indefinitely after MIN_GO. The counter saturates and never wraps.
- Own req dropping before MIN_GO does not shorten GO.
- SLOW: lasts exactly SLOW_CYC cycles, then → CLEAR (or straight to arbitration if CLEAR_CYC=0). req is ignored during SLOW.
- CLEAR: all channels STOP for CLEAR_CYC cycles. Then, if any req is high, go → GO for the round-robin winner; otherwise → IDLE.
- The channel just served is the lowest priority at the next arbitration. If it is the only requester it is re-granted after the clearance.
- Simultaneous requests: the lowest index after active_ch wins. The others wait, and none is starved: each is served within NUM_CH grants.
- A req deasserted while waiting is simply dropped; requests are not latched.
- error is checked every cycle on the registered state. It is sticky until reset and must never fire in correct operation.

Decomposition:
- Shared package lights_pkg holds:
  - the light encodings ST_STOP/ST_GO/ST_SLOW (3-bit);
  - the ctrl_state_t enum {IDLE, GO, SLOW, CLEAR};
  - a function onehot3_ok().
- Sub-module rr_pick: combinational round-robin arbiter. Inputs are req[NUM_CH] and last[$clog2(NUM_CH)]. Outputs are valid and idx. It is reused by later multi-channel controllers.
- The main FSM, dwell counter and output registers live in lights_rr_ctrl. The controller FSM carries the covered_fsm attribute with is/os set to the current and next controller state.

Test Plan:
1. Reset, then req=4'b0000 for 20 cycles → all fields 3'b001, busy=0, error=0, active_ch=3.
2. req=4'b0100 held for 10 cycles, then dropped → cycle after rise: ch2=GO, active_ch=2. GO persists while req is held. After the drop: SLOW for 2 cycles, CLEAR for 1 cycle, then IDLE.
3. req=4'b0010 pulsed for 1 cycle → ch1 GO for exactly MIN_GO=4 cycles, SLOW 2, CLEAR 1, then IDLE.
4. req=4'b1111 held → grant order 0,1,2,3,0. Each GO is 16 cycles (MAX_GO), and at most one field is non-STOP at any time.
5. ch0 in GO with req=4'b0001 held for 300 cycles → stays GO, counter saturates at 255, no wrap and no SLOW. Then raise req[3] → ch0 enters SLOW on the next cycle.
6. Drive rst_n low mid-SLOW of ch1 → all fields 3'b001 within the same cycle (asynchronous). After rst_n rises with req=4'b0010, ch1 is GO 1 cycle later; error stays 0 throughout.
